// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, program ids,
// default widths and the per-program branch-pointer windows.
package fetch_pkg;

    localparam int PC_W  = 10;
    localparam int PTR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PROG_NONE = 2'd0,
        PROG_1    = 2'd1,
        PROG_2    = 2'd2,
        PROG_3    = 2'd3
    } prog_t;

    // Branch-target pointer ranges owned by each resident program
    localparam int P1_LO = 0;
    localparam int P1_HI = 9;
    localparam int P2_LO = 10;
    localparam int P2_HI = 14;
    localparam int P3_LO = 15;
    localparam int P3_HI = 15;

endpackage

// File: rtl/fetch_sequencer_branch_target_rom.sv
// Combinational branch-target table: maps an instruction's pointer field to an
// absolute PC.
module branch_target_rom #(
    parameter int PC_W  = fetch_pkg::PC_W,
    parameter int PTR_W = fetch_pkg::PTR_W
) (
    input  logic [PTR_W-1:0] ptr,
    output logic [PC_W-1:0]  target
);

    always_comb begin
        target = PC_W'(1);
        case (int'(ptr))
            0:       target = PC_W'(13);
            1:       target = PC_W'(22);
            2:       target = PC_W'(43);
            3:       target = PC_W'(62);
            4:       target = PC_W'(74);
            5:       target = PC_W'(93);
            6:       target = PC_W'(99);
            7:       target = PC_W'(105);
            8:       target = PC_W'(107);
            9:       target = PC_W'(109);
            default: target = PC_W'(1);
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC controller with Start/Ack harness handshake and branch resolution.
// Optional cycle counter output enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_sequencer #(
    parameter int PC_W     = fetch_pkg::PC_W,
    parameter int PTR_W    = fetch_pkg::PTR_W,
    parameter int P1_START = 0,
    parameter int P2_START = 300,
    parameter int P3_START = 600
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ProgSel,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchTaken,
    input  logic [PTR_W-1:0] LutPointer,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Ack,
    output logic             Fault,
    output logic [1:0]       ActiveProg
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [15:0]      CycleCount
`endif
);

    import fetch_pkg::*;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    prog_t           prog_q, prog_d;
    logic [PC_W-1:0] br_target;
    logic            ptr_ok;

    branch_target_rom #(
        .PC_W  (PC_W),
        .PTR_W (PTR_W)
    ) u_rom (
        .ptr    (LutPointer),
        .target (br_target)
    );

    function automatic logic [PC_W-1:0] start_pc(input prog_t p);
        case (p)
            PROG_2:  return PC_W'(P2_START);
            PROG_3:  return PC_W'(P3_START);
            default: return PC_W'(P1_START);
        endcase
    endfunction

    function automatic logic ptr_in_window(input prog_t p, input logic [PTR_W-1:0] ptr);
        int v;
        v = int'(ptr);
        case (p)
            PROG_1:  return (v >= P1_LO) && (v <= P1_HI);
            PROG_2:  return (v >= P2_LO) && (v <= P2_HI);
            PROG_3:  return (v >= P3_LO) && (v <= P3_HI);
            default: return 1'b0;
        endcase
    endfunction

    assign ptr_ok = ptr_in_window(prog_q, LutPointer);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        prog_d  = prog_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && (ProgSel != 2'd0)) begin
                    prog_d  = prog_t'(ProgSel);
                    pc_d    = start_pc(prog_t'(ProgSel));
                    fault_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stall outranks Halt and branches: nothing advances this cycle
                if (Stall) begin
                    state_d = ST_RUN;
                end else if (Halt) begin
                    state_d = ST_DONE;
                end else if (BranchTaken) begin
                    if (ptr_ok) begin
                        pc_d = br_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (pc_q == '1) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_DONE: begin
                // Harness must drop Start before another program can be launched
                if (!Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            fault_q <= 1'b0;
            prog_q  <= PROG_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            prog_q  <= prog_d;
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && Start && (ProgSel != 2'd0)) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUN) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CycleCount = cnt_q;
`endif

    assign PC         = pc_q;
    assign Running    = (state_q == ST_RUN);
    assign Ack        = (state_q == ST_DONE);
    assign Fault      = fault_q;
    assign ActiveProg = prog_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each stimulus cycle queues the expected
// post-edge outputs, and a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [1:0] ProgSel;
    logic       Stall;
    logic       Halt;
    logic       BranchTaken;
    logic [3:0] LutPointer;
    logic [9:0] PC;
    logic       Running;
    logic       Ack;
    logic       Fault;
    logic [1:0] ActiveProg;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] CycleCount;
`endif

    fetch_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .ProgSel     (ProgSel),
        .Stall       (Stall),
        .Halt        (Halt),
        .BranchTaken (BranchTaken),
        .LutPointer  (LutPointer),
        .PC          (PC),
        .Running     (Running),
        .Ack         (Ack),
        .Fault       (Fault),
        .ActiveProg  (ActiveProg)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .CycleCount  (CycleCount)
`endif
    );

    typedef struct {
        int pc;
        int run;
        int ack;
        int fault;
        int prog;
        int cnt;
        int step;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int step, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, want);
        end
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", e.step, int'(PC), e.pc);
            chk("running", e.step, int'(Running), e.run);
            chk("ack", e.step, int'(Ack), e.ack);
            chk("fault", e.step, int'(Fault), e.fault);
            chk("active_prog", e.step, int'(ActiveProg), e.prog);
`ifdef FETCH_CYCLE_CNT_EN
            if (e.cnt >= 0) chk("cycle_count", e.step, int'(CycleCount), e.cnt);
`endif
        end
    end

    // Drive one cycle of inputs, then queue the outputs expected after that edge
    task automatic cyc(input bit rst_n, input bit st, input int sel, input bit stall,
                       input bit halt, input bit br, input int ptr,
                       input int pc, input int run, input int ack, input int fault,
                       input int prog, input int cnt = -1);
        exp_t e;
        @(negedge Clk);
        Reset       = rst_n;
        Start       = st;
        ProgSel     = sel[1:0];
        Stall       = stall;
        Halt        = halt;
        BranchTaken = br;
        LutPointer  = ptr[3:0];
        @(posedge Clk);
        #1;
        step_no++;
        e.pc = pc; e.run = run; e.ack = ack; e.fault = fault;
        e.prog = prog; e.cnt = cnt; e.step = step_no;
        sb.push_back(e);
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; ProgSel = 2'd0; Stall = 1'b0;
        Halt = 1'b0; BranchTaken = 1'b0; LutPointer = 4'd0;

        // Power-on reset
        cyc(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        // Program 1 launch and sequential fetch
        cyc(1, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 0, 0, 0, 0,   i, 1, 0, 0, 1);

        // Stall drops the branch; unstalled branch to ptr 2 -> 43
        cyc(1, 0, 0, 1, 0, 1, 2,   3, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 2,   43, 1, 0, 0, 1);
        for (int i = 44; i <= 57; i++) cyc(1, 0, 0, 0, 0, 0, 0,   i, 1, 0, 0, 1);

        // Reset mid-RUN at PC=57
        cyc(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        // Program 2: out-of-window pointer faults; next accepted Start clears it
        cyc(1, 1, 2, 0, 0, 0, 0,   300, 1, 0, 0, 2);
        cyc(1, 0, 0, 0, 0, 1, 3,   300, 0, 1, 1, 2);
        cyc(1, 0, 0, 0, 0, 0, 0,   300, 0, 0, 1, 2);
        cyc(1, 1, 2, 0, 0, 0, 0,   300, 1, 0, 0, 2);
        cyc(1, 0, 0, 0, 0, 1, 12,  1, 1, 0, 0, 2);
        cyc(1, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 2);
        cyc(1, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 2);
        cyc(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2);

        // Program 1: branch to 109, step to 110, Halt with Start held high
        cyc(1, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 9,   109, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0,   110, 1, 0, 0, 1);
        cyc(1, 1, 1, 0, 1, 0, 0,   110, 0, 1, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0,   110, 0, 1, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0,   110, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0,   110, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0,   110, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0,   110, 0, 0, 0, 1);

        // Program 3: ptr 15 in window, ptr 14 faults
        cyc(1, 1, 3, 0, 0, 0, 0,   600, 1, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 1, 15,  1, 1, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 1, 14,  1, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 3);

        // Top-of-address-space: no wrap past 1023
        cyc(1, 1, 3, 0, 0, 0, 0,   600, 1, 0, 0, 3);
        for (int i = 601; i <= 1023; i++) cyc(1, 0, 0, 0, 0, 0, 0,   i, 1, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 0, 0,   1023, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 0, 0,   1023, 0, 0, 1, 3);

        // Cycle counter: 5 RUN cycles (2 stalled) plus the Halt edge -> 6
        cyc(1, 1, 3, 0, 0, 0, 0,   600, 1, 0, 0, 3, 0);
        cyc(1, 1, 1, 0, 0, 0, 0,   601, 1, 0, 0, 3, 1);
        cyc(1, 0, 0, 1, 0, 0, 0,   601, 1, 0, 0, 3, 2);
        cyc(1, 0, 0, 0, 0, 0, 0,   602, 1, 0, 0, 3, 3);
        cyc(1, 0, 0, 1, 0, 1, 15,  602, 1, 0, 0, 3, 4);
        cyc(1, 0, 0, 0, 0, 0, 0,   603, 1, 0, 0, 3, 5);
        cyc(1, 1, 0, 0, 1, 0, 0,   603, 0, 1, 0, 3, 6);
        cyc(1, 1, 0, 0, 0, 0, 0,   603, 0, 1, 0, 3, 6);
        cyc(1, 0, 0, 0, 0, 0, 0,   603, 0, 0, 0, 3, 6);

        repeat (2) @(negedge Clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller for the single-cycle core. It owns the PC register and runs the Start/Ack handshake with the test harness.
- It selects one of three resident programs and resolves taken branches to absolute targets through the branch-target lookup.
- It sits between the harness, the decoder (Halt/BranchTaken/LutPointer) and instruction memory (PC).

Parameters:
- PC_W, 10, PC and target width
- PTR_W, 4, branch-target pointer width
- P1_START, 0, first PC of program 1
- P2_START, 300, first PC of program 2
- P3_START, 600, first PC of program 3

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  harness request; level-held until Ack
- ProgSel  in  2  program to run: 1, 2 or 3 (0 is invalid)
- Stall  in  1  hold PC this cycle
- Halt  in  1  decoder: current instruction ends the program
- BranchTaken  in  1  decoder: taken branch this cycle
- LutPointer  in  PTR_W  branch-target index from the instruction
- PC  out  PC_W  registered fetch address
- Running  out  1  high in RUN
- Ack  out  1  high in DONE
- Fault  out  1  sticky error flag, cleared by next accepted Start
- ActiveProg  out  2  program currently or last run

Behaviour:
- Reset (Reset==0 at posedge):
  - state=IDLE; PC=0, Running=0, Ack=0, Fault=0, ActiveProg=0.
  - Reset overrides everything, including mid-RUN.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - Start=1 with ProgSel in {1,2,3}: next edge loads PC=Pn_START, ActiveProg=ProgSel, Fault=0, state→RUN.
  - Start with ProgSel=0: ignored; stay IDLE, no Fault.
- RUN, priority order per edge:
  1. Stall=1: hold PC and state. Halt and branch are ignored this cycle.
  2. Halt=1: hold PC, state→DONE.
  3. BranchTaken=1: check LutPointer against the ActiveProg window (P1 0–9, P2 10–14, P3 15).
     - In window: PC←target next edge. Zero bubbles.
     - Out of window: Fault←1, PC held, state→DONE.
  4. Otherwise PC←PC+1. If PC is already 2^PC_W−1: no wrap; Fault←1, state→DONE.
- Start/ProgSel changes during RUN are ignored.
- DONE:
  - Ack=1.
  - Start=0 at edge: state→IDLE, Ack drops on the following cycle.
  - Start still high: remain in DONE; no restart without a Start low phase.
- Latency:
  - Start accepted at edge t: Running=1 and PC=Pn_START after edge t.
  - Halt at edge t: Ack=1 after edge t.
- Target lookup is combinational. Contents: 0→13, 1→22, 2→43, 3→62, 4→74, 5→93, 6→99, 7→105, 8→107, 9→109, 10–15→1.

Optional Feature:
- Macro: FETCH_CYCLE_CNT_EN
- Defined:
  - Extra output CycleCount [15:0]; cleared on accepted Start.
  - Increments on every RUN cycle, stalls included; saturates at 0xFFFF.
  - Holds its value through DONE and IDLE until the next accepted Start. Reset clears it to 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - PC_W/PTR_W localparams
  - per-program window bounds (LO/HI) and the prog-id typedef
- One sub-module, branch_target_rom: pure combinational pointer→target table, instantiated once.
- Window check and FSM stay in fetch_sequencer.

Test Plan:
- Reset low 2 cycles mid-RUN, PC=57 → PC=0, Running=0, Ack=0, Fault=0, IDLE.
- Start=1, ProgSel=1 → next cycle PC=0, Running=1. Then 3 non-branch cycles → PC=3.
- Prog1 RUN, BranchTaken=1, LutPointer=2 → PC=43 next cycle. Same cycle with Stall=1 → PC unchanged, branch dropped.
- Prog2 RUN, BranchTaken=1, LutPointer=3 → Fault=1, Ack=1, PC held. Next Start with ProgSel=2 clears Fault.
- Halt at PC=110 with Start held high → Ack=1 persists. Start low → IDLE one cycle later. Start with ProgSel=0 → stays IDLE.
- FETCH_CYCLE_CNT_EN defined: run prog3 for 5 RUN cycles including 2 stalls, then Halt → CycleCount=6 (the Halt edge is a RUN cycle) and stable in DONE.
